classify_module: RTL
====================

Name: classify_module

Overview:
- Final stage of the CNN solver. Sits downstream of the step-2 fully-connected stage.
- Starts once step 2 reports finish. Reads the NUM_CLASSES ReLU'd class scores that step 2 wrote to output SRAM (dom) and computes the argmax.
- Writes the winning class index back to dom at RESULT_ADDR, then signals done to the controller.

Parameters:
- NUM_CLASSES, 8, number of class scores to scan (≥2, power of 2 not required).
- DATA_W, 16, score width; scores are unsigned, since step 2 clamps negatives to 0.
- ADDR_W, 4, dom address width.
- IDX_W, 3, class index width; must satisfy 2^IDX_W ≥ NUM_CLASSES.
- BASE_ADDR, 0, dom address of class 0 score.
- RESULT_ADDR, 8, dom address receiving the result word.
- RD_LATENCY, 1, SRAM read latency in cycles (1 or 2).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse from controller; honoured only in IDLE.
- rd_en  output  1  dom read enable.
- rd_addr  output  ADDR_W  dom read address.
- rd_data  input  DATA_W  dom read data, valid RD_LATENCY cycles after rd_en.
- wr_en  output  1  dom write enable.
- wr_addr  output  ADDR_W  dom write address.
- wr_data  output  DATA_W  result word: {max_val[DATA_W-1-IDX_W:0], class_idx}.
- class_idx  output  IDX_W  winning class, held until next start.
- max_val  output  DATA_W  winning score, held until next start.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse when the result is written.

Behaviour:
- Reset values: all outputs 0; FSM returns to IDLE; internal counters, valid pipeline and running max all cleared.
- Reset mid-operation aborts immediately. No write is issued, and a pending done is dropped.
- FSM states:
  - IDLE: on start go to READ; clear rd_cnt, running max (0) and running index (0).
  - READ: assert rd_en with rd_addr = BASE_ADDR + rd_cnt, one address per cycle. rd_cnt increments each cycle. After the cycle with rd_cnt = NUM_CLASSES-1, go to DRAIN.
  - DRAIN: rd_en = 0. Stay until the last score has been compared, i.e. the valid pipeline is empty; then go to WRITE.
  - WRITE: one cycle. wr_en = 1, wr_addr = RESULT_ADDR, wr_data as above, done = 1; go to IDLE.
- Read-data alignment:
  - rd_en is delayed by an RD_LATENCY-deep shift register to form data_vld.
  - A compare counter cmp_cnt (0..NUM_CLASSES-1) advances on each data_vld.
- Compare rule:
  - On data_vld, if rd_data > running max (strictly greater, unsigned), update running max = rd_data and running index = cmp_cnt.
  - Ties therefore resolve to the lowest index.
  - The first score is compared against 0, so an all-zero vector yields index 0, max 0.
- class_idx and max_val update from the running registers on entry to WRITE, and hold until the next start.
- Timing, with start sampled at edge T and RD_LATENCY = 1:
  - rd_en high in cycles T+1 .. T+NUM_CLASSES.
  - Last data valid in cycle T+NUM_CLASSES+1.
  - wr_en and done high in cycle T+NUM_CLASSES+2 (T+10 for defaults).
  - Each extra RD_LATENCY cycle adds 1 cycle.
- start while busy is ignored; no queuing.
- start coincident with reset: reset wins.
- wr_en and rd_en are never high in the same cycle.
- rd_addr and wr_addr are held at 0 when their enable is low.
- wr_data truncation: max_val is truncated to its low DATA_W-IDX_W bits (13 bits for defaults). class_idx occupies the low IDX_W bits.

Test Plan:
- Scores {5,9,3,0x7FFF,2,1,0,4}, start pulse:
  - rd_addr 0..7 in cycles T+1..T+8.
  - At T+10: wr_en=1, wr_addr=8, class_idx=3, max_val=0x7FFF, wr_data=0xFFFB, done=1.
- All scores 0 -> class_idx=0, max_val=0, wr_data=0x0000, done at T+10.
- Ties {1,8,8,2,8,0,0,0} -> class_idx=1, max_val=8, wr_data=0x0041.
- Max in last slot, {0,0,0,0,0,0,0,0xFFFF}, unsigned compare -> class_idx=7, max_val=0xFFFF. Also repeat with RD_LATENCY=2 -> done at T+11.
- Second start pulse at T+4 during READ -> ignored: one write only, done exactly once at T+10, busy high T+1..T+10.
- reset asserted at T+5 -> next cycle busy=0, rd_en=0, class_idx=0, no wr_en or done. A fresh start afterwards completes normally with correct result.

Source files
------------

// File: rtl/classify_module.sv
// Argmax stage: scans NUM_CLASSES unsigned scores from output SRAM,
// then writes {max_val low bits, class_idx} back at RESULT_ADDR.
module classify_module #(
    parameter int NUM_CLASSES = 8,
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 4,
    parameter int IDX_W       = 3,
    parameter int BASE_ADDR   = 0,
    parameter int RESULT_ADDR = 8,
    parameter int RD_LATENCY  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [IDX_W-1:0]  class_idx,
    output logic [DATA_W-1:0] max_val,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE
    } state_e;

    state_e state_q, state_d;

    logic [IDX_W-1:0]      rd_cnt_q, rd_cnt_d;
    logic [IDX_W-1:0]      cmp_cnt_q, cmp_cnt_d;
    logic [IDX_W-1:0]      run_idx_q, run_idx_d;
    logic [IDX_W-1:0]      cls_q, cls_d;
    logic [DATA_W-1:0]     run_max_q, run_max_d;
    logic [DATA_W-1:0]     max_q, max_d;
    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [RD_LATENCY-1:0] vld_older;
    logic                  data_vld;
    logic                  take;

    always_comb begin
        data_vld  = vld_q[RD_LATENCY-1];
        take      = data_vld && (rd_data > run_max_q);
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        cmp_cnt_d = data_vld ? cmp_cnt_q + 1'b1 : cmp_cnt_q;
        run_max_d = take ? rd_data : run_max_q;
        run_idx_d = take ? cmp_cnt_q : run_idx_q;
        cls_d     = cls_q;
        max_d     = max_q;
        rd_en     = 1'b0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        done      = 1'b0;
        busy      = (state_q != S_IDLE);
        // Stages still in flight besides the one being compared now.
        vld_older = vld_q;
        vld_older[RD_LATENCY-1] = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_READ;
                    rd_cnt_d  = '0;
                    cmp_cnt_d = '0;
                    run_max_d = '0;
                    run_idx_d = '0;
                end
            end
            S_READ: begin
                rd_en    = 1'b1;
                rd_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(rd_cnt_q);
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_cnt_q == IDX_W'(NUM_CLASSES - 1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (vld_older == '0) begin
                    state_d = S_WRITE;
                    cls_d   = run_idx_d;
                    max_d   = run_max_d;
                end
            end
            S_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = ADDR_W'(RESULT_ADDR);
                wr_data = {max_q[DATA_W-IDX_W-1:0], cls_q};
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        vld_d = (vld_q << 1) | RD_LATENCY'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rd_cnt_q  <= '0;
            cmp_cnt_q <= '0;
            run_idx_q <= '0;
            run_max_q <= '0;
            cls_q     <= '0;
            max_q     <= '0;
            vld_q     <= '0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            cmp_cnt_q <= cmp_cnt_d;
            run_idx_q <= run_idx_d;
            run_max_q <= run_max_d;
            cls_q     <= cls_d;
            max_q     <= max_d;
            vld_q     <= vld_d;
        end
    end

    assign class_idx = cls_q;
    assign max_val   = max_q;

endmodule
